spio_link_rate_adapter: RTL and testbench

//   Single-clock rdy/vld rate adapter between a full-rate side and a side that

---
 rtl/spio_link_rate_adapter.sv | 115 +++++++++++
 tb/tb_spio_link_rate_adapter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spio_link_rate_adapter.sv
// Single-clock rdy/vld rate adapter: one side transfers every cycle, the other only on
// STROBE_OUT cycles (once per RATIO clocks), with a DEPTH-entry FIFO between them.
module spio_link_rate_adapter #(
    parameter int PKT_BITS  = 72,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 4,
    parameter int SLOW_SIDE = 0
) (
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic                SYNC_IN,
    output logic                STROBE_OUT,
    input  logic [PKT_BITS-1:0] DATA_IN,
    input  logic                VLD_IN,
    output logic                RDY_OUT,
    output logic [PKT_BITS-1:0] DATA_OUT,
    output logic                VLD_OUT,
    input  logic                RDY_IN
);

    localparam int PH_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(RATIO - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam bit               IN_SLOW  = (SLOW_SIDE == 0);
    localparam bit               OUT_SLOW = (SLOW_SIDE != 0);

    logic [PH_W-1:0]     phase;
    logic [PH_W-1:0]     phase_nxt;
    logic                in_en;
    logic                out_en;
    logic                push;
    logic                pop;
    logic                bypass;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_nxt;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic [PKT_BITS-1:0] head_nxt;
    logic [PKT_BITS-1:0] mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // SYNC_IN only moves the phase that follows; the current cycle's strobe still stands.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        phase_nxt = phase + PH_W'(1);
        if (SYNC_IN || (phase == PH_LAST)) begin
            phase_nxt = '0;
        end
    end

    assign in_en  = IN_SLOW  ? STROBE_OUT : 1'b1;
    assign out_en = OUT_SLOW ? STROBE_OUT : 1'b1;
    assign push   = VLD_IN && RDY_OUT && in_en;
    assign pop    = VLD_OUT && RDY_IN && out_en;
    assign rd_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // A word pushed into an otherwise empty FIFO is not in storage yet, so forward it.
    assign bypass   = push && (count_nxt == CNT_W'(1));
    assign head_nxt = bypass ? DATA_IN : mem[rd_nxt];

    // NOTE: storage is deliberately not reset; count alone says which entries are valid.
    always_ff @(posedge CLK_IN) begin
        if (push) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            phase      <= '0;
            STROBE_OUT <= (RATIO == 1);
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            RDY_OUT    <= 1'b0;
            VLD_OUT    <= 1'b0;
            DATA_OUT   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            phase      <= phase_nxt;
            STROBE_OUT <= (phase_nxt == PH_LAST);
            rd_ptr     <= rd_nxt;
            count      <= count_nxt;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            // Slow-side outputs move only on the edge that ends a strobe cycle.
            if (in_en) begin
                RDY_OUT <= (count_nxt < CNT_FULL);
            end
            if (out_en) begin
                VLD_OUT  <= (count_nxt != '0);
                DATA_OUT <= head_nxt;
            end
        end
    end

endmodule

// File: tb/tb_spio_link_rate_adapter.sv
// Self-checking bench: four adapter configurations, a table of hand-derived vectors,
// directed multi-cycle sequences, and random traffic against a queue-based model.
module tb_spio_link_rate_adapter;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic        sync    [N];
    logic        vld_in  [N];
    logic        rdy_in  [N];
    logic        strobe  [N];
    logic        rdy_out [N];
    logic        vld_out [N];
    logic [71:0] din     [N];
    logic [71:0] dout    [N];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: packets held, slow-phase position, and expected outputs.
    logic [71:0] mq     [N][$];
    int          m_cyc  [N];
    logic        m_rdy  [N];
    logic        m_vld  [N];
    logic [71:0] m_data [N];

    typedef struct {
        logic        vld;
        logic [71:0] d;
        logic        rdy;
        logic        e_rdy;
        logic        e_vld;
        logic [71:0] e_d;
    } vec_t;

    vec_t tbl [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spio_link_rate_adapter #(.PKT_BITS(72), .RATIO(2), .DEPTH(4), .SLOW_SIDE(0)) u0 (
        .CLK_IN(clk), .RESET_IN(rst_n), .SYNC_IN(sync[0]), .STROBE_OUT(strobe[0]),
        .DATA_IN(din[0]), .VLD_IN(vld_in[0]), .RDY_OUT(rdy_out[0]),
        .DATA_OUT(dout[0]), .VLD_OUT(vld_out[0]), .RDY_IN(rdy_in[0]));

    spio_link_rate_adapter #(.PKT_BITS(72), .RATIO(3), .DEPTH(4), .SLOW_SIDE(0)) u1 (
        .CLK_IN(clk), .RESET_IN(rst_n), .SYNC_IN(sync[1]), .STROBE_OUT(strobe[1]),
        .DATA_IN(din[1]), .VLD_IN(vld_in[1]), .RDY_OUT(rdy_out[1]),
        .DATA_OUT(dout[1]), .VLD_OUT(vld_out[1]), .RDY_IN(rdy_in[1]));

    spio_link_rate_adapter #(.PKT_BITS(72), .RATIO(4), .DEPTH(4), .SLOW_SIDE(1)) u2 (
        .CLK_IN(clk), .RESET_IN(rst_n), .SYNC_IN(sync[2]), .STROBE_OUT(strobe[2]),
        .DATA_IN(din[2]), .VLD_IN(vld_in[2]), .RDY_OUT(rdy_out[2]),
        .DATA_OUT(dout[2]), .VLD_OUT(vld_out[2]), .RDY_IN(rdy_in[2]));

    spio_link_rate_adapter #(.PKT_BITS(72), .RATIO(1), .DEPTH(1), .SLOW_SIDE(0)) u3 (
        .CLK_IN(clk), .RESET_IN(rst_n), .SYNC_IN(sync[3]), .STROBE_OUT(strobe[3]),
        .DATA_IN(din[3]), .VLD_IN(vld_in[3]), .RDY_OUT(rdy_out[3]),
        .DATA_OUT(dout[3]), .VLD_OUT(vld_out[3]), .RDY_IN(rdy_in[3]));

    function automatic int rat(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int dep(input int i);
        return (i == 3) ? 1 : 4;
    endfunction

    function automatic int slow_out(input int i);
        return (i == 2) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_cyc[i]  = 0;
            m_rdy[i]  = 1'b0;
            m_vld[i]  = 1'b0;
            m_data[i] = '0;
        end
    endtask

    // One clock of the adapter's rules, applied to pre-edge inputs and model state.
    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit st;
            bit en_in;
            bit en_out;
            bit push;
            bit pop;
            st     = (m_cyc[i] % rat(i)) == (rat(i) - 1);
            en_in  = (slow_out(i) == 0) ? st : 1'b1;
            en_out = (slow_out(i) == 1) ? st : 1'b1;
            push   = vld_in[i] && m_rdy[i] && en_in;
            pop    = m_vld[i] && rdy_in[i] && en_out;
            if (pop) void'(mq[i].pop_front());
            if (push) mq[i].push_back(din[i]);
            if (en_in) m_rdy[i] = (mq[i].size() < dep(i));
            if (en_out) begin
                m_vld[i] = (mq[i].size() > 0);
                if (m_vld[i]) m_data[i] = mq[i][0];
            end
            m_cyc[i] = sync[i] ? 0 : (m_cyc[i] + 1) % rat(i);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d strobe", i), strobe[i], (m_cyc[i] == rat(i) - 1));
            check($sformatf("u%0d rdy_out", i), rdy_out[i], m_rdy[i]);
            check($sformatf("u%0d vld_out", i), vld_out[i], m_vld[i]);
            if (!rst_n) check($sformatf("u%0d data_out in reset", i), dout[i], '0);
            else if (m_vld[i]) check($sformatf("u%0d data_out", i), dout[i], m_data[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        compare_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   nxt;
        int   cnt;
        int   acc;
        int   got_n;
        logic fire;
        logic prev_rdy;
        logic prev_st;
        logic prev_vld;
        logic [71:0] prev_d;
        logic [71:0] got_d [16];
        int          got_c [16];
        int          first_st [N];

        tbl[0] = '{vld: 1'b1, d: 72'h11, rdy: 1'b0, e_rdy: 1'b1, e_vld: 1'b0, e_d: 72'h0};
        tbl[1] = '{vld: 1'b1, d: 72'h22, rdy: 1'b0, e_rdy: 1'b0, e_vld: 1'b1, e_d: 72'h22};
        tbl[2] = '{vld: 1'b1, d: 72'h33, rdy: 1'b1, e_rdy: 1'b1, e_vld: 1'b0, e_d: 72'h0};
        tbl[3] = '{vld: 1'b1, d: 72'h44, rdy: 1'b1, e_rdy: 1'b0, e_vld: 1'b1, e_d: 72'h44};
        tbl[4] = '{vld: 1'b0, d: 72'h55, rdy: 1'b0, e_rdy: 1'b0, e_vld: 1'b1, e_d: 72'h44};
        tbl[5] = '{vld: 1'b0, d: 72'h66, rdy: 1'b1, e_rdy: 1'b1, e_vld: 1'b0, e_d: 72'h0};
        tbl[6] = '{vld: 1'b0, d: 72'h77, rdy: 1'b1, e_rdy: 1'b1, e_vld: 1'b0, e_d: 72'h0};

        for (int i = 0; i < N; i++) begin
            sync[i] = 1'b0; vld_in[i] = 1'b0; rdy_in[i] = 1'b0; din[i] = '0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset u%0d strobe", i), strobe[i], (rat(i) == 1));
            check($sformatf("reset u%0d rdy_out", i), rdy_out[i], 1'b0);
            check($sformatf("reset u%0d vld_out", i), vld_out[i], 1'b0);
            check($sformatf("reset u%0d data_out", i), dout[i], '0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain one-entry FIFO (RATIO=1, DEPTH=1), vectors derived cycle by cycle.
        for (int v = 0; v < 7; v++) begin
            vld_in[3] = tbl[v].vld; din[3] = tbl[v].d; rdy_in[3] = tbl[v].rdy;
            step();
            check($sformatf("tbl[%0d] strobe", v), strobe[3], 1'b1);
            check($sformatf("tbl[%0d] rdy_out", v), rdy_out[3], tbl[v].e_rdy);
            check($sformatf("tbl[%0d] vld_out", v), vld_out[3], tbl[v].e_vld);
            if (tbl[v].e_vld) check($sformatf("tbl[%0d] data_out", v), dout[3], tbl[v].e_d);
        end
        vld_in[3] = 1'b0; rdy_in[3] = 1'b0;

        // T1: slow input 1..8 back-to-back, fast output always ready.
        vld_in[0] = 1'b1; din[0] = 72'd1; rdy_in[0] = 1'b1; nxt = 1; got_n = 0;
        for (int c = 0; c < 40; c++) begin
            fire = vld_in[0] && rdy_out[0] && strobe[0];
            if (vld_out[0]) begin
                if (got_n < 16) begin got_d[got_n] = dout[0]; got_c[got_n] = c; end
                got_n++;
            end
            step();
            if (fire) begin
                nxt++;
                if (nxt > 8) vld_in[0] = 1'b0;
                else din[0] = 72'(nxt);
            end
        end
        check("T1 words delivered", got_n, 8);
        for (int k = 0; k < 8 && k < got_n; k++) begin
            check($sformatf("T1 word %0d", k), got_d[k], 72'(k + 1));
            if (k > 0) check($sformatf("T1 gap %0d", k), got_c[k] - got_c[k-1], 2);
        end
        rdy_in[0] = 1'b0;

        // T2: output stalled for 20 clocks, RATIO=3 slow input.
        vld_in[1] = 1'b1; din[1] = 72'd1; rdy_in[1] = 1'b0; acc = 0;
        for (int c = 0; c < 20; c++) begin
            fire = vld_in[1] && rdy_out[1] && strobe[1];
            prev_rdy = rdy_out[1]; prev_st = strobe[1];
            step();
            if (fire) begin acc++; din[1] = 72'(acc + 1); end
            if (prev_rdy && !rdy_out[1]) check("T2 rdy_out falls after strobe", prev_st, 1'b1);
        end
        check("T2 words accepted", acc, 4);
        check("T2 rdy_out low when full", rdy_out[1], 1'b0);
        vld_in[1] = 1'b0; rdy_in[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("T2 drain vld %0d", k), vld_out[1], 1'b1);
            check($sformatf("T2 drain data %0d", k), dout[1], 72'(k + 1));
            step();
        end
        check("T2 empty after 4 clocks", vld_out[1], 1'b0);
        rdy_in[1] = 1'b0;

        // T3: fast input burst A0..A3 into a RATIO=4 slow output.
        vld_in[2] = 1'b1; din[2] = 72'hA0; rdy_in[2] = 1'b1; got_n = 0;
        for (int c = 0; c < 30; c++) begin
            fire = vld_in[2] && rdy_out[2];
            if (vld_out[2] && strobe[2]) begin
                if (got_n < 16) begin got_d[got_n] = dout[2]; got_c[got_n] = c; end
                got_n++;
            end
            prev_vld = vld_out[2]; prev_d = dout[2]; prev_st = strobe[2];
            step();
            if ((vld_out[2] !== prev_vld) || (dout[2] !== prev_d))
                check("T3 output moves only after strobe", prev_st, 1'b1);
            if (fire) begin
                if (din[2] == 72'hA3) vld_in[2] = 1'b0;
                else din[2] = din[2] + 72'd1;
            end
        end
        check("T3 words popped", got_n, 4);
        for (int k = 0; k < 4 && k < got_n; k++) begin
            check($sformatf("T3 word %0d", k), got_d[k], 72'hA0 + 72'(k));
            if (k > 0) check($sformatf("T3 strobe gap %0d", k), got_c[k] - got_c[k-1], 4);
        end
        rdy_in[2] = 1'b0;

        // T4: SYNC pulse during phase 1 restarts the RATIO=4 period.
        cnt = 0;
        while (!strobe[2] && cnt < 8) begin step(); cnt++; end
        check("T4 strobe found", strobe[2], 1'b1);
        step(); step();
        sync[2] = 1'b1;
        step();
        sync[2] = 1'b0;
        cnt = 1;
        while (!strobe[2] && cnt < 10) begin step(); cnt++; end
        check("T4 clocks from sync to strobe", cnt, 4);

        // T4b: a pop on a strobe that coincides with SYNC still completes.
        check("T4 rdy_out before push", rdy_out[2], 1'b1);
        vld_in[2] = 1'b1; din[2] = 72'h5A;
        step();
        vld_in[2] = 1'b0;
        cnt = 0;
        while (!vld_out[2] && cnt < 8) begin step(); cnt++; end
        check("T4 word presented", vld_out[2], 1'b1);
        cnt = 0;
        while (!strobe[2] && cnt < 8) begin step(); cnt++; end
        check("T4 data at sync strobe", dout[2], 72'h5A);
        rdy_in[2] = 1'b1; sync[2] = 1'b1;
        step();
        rdy_in[2] = 1'b0; sync[2] = 1'b0;
        check("T4 popped on sync strobe", vld_out[2], 1'b0);
        check("T4 no strobe right after sync", strobe[2], 1'b0);

        // T5: reset mid-period with three words queued.
        vld_in[0] = 1'b1; din[0] = 72'h31; rdy_in[0] = 1'b0; acc = 0; cnt = 0;
        while (acc < 3 && cnt < 20) begin
            fire = vld_in[0] && rdy_out[0] && strobe[0];
            step(); cnt++;
            if (fire) begin acc++; din[0] = din[0] + 72'd1; end
        end
        check("T5 words queued", acc, 3);
        vld_in[0] = 1'b0;
        step();
        cnt = 0;
        while (strobe[0] && cnt < 4) begin step(); cnt++; end
        check("T5 queued vld_out", vld_out[0], 1'b1);
        #4 rst_n = 1'b0;
        #1;
        check("T5 vld_out cleared", vld_out[0], 1'b0);
        check("T5 rdy_out cleared", rdy_out[0], 1'b0);
        check("T5 strobe cleared", strobe[0], 1'b0);
        model_reset();
        compare_all();
        #2 rst_n = 1'b1;
        for (int i = 0; i < N; i++) first_st[i] = -1;
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < N; i++)
                if (first_st[i] < 0 && strobe[i]) first_st[i] = s;
            step();
        end
        for (int i = 0; i < N; i++)
            check($sformatf("T5 u%0d edges to first strobe", i), first_st[i], rat(i) - 1);

        // T6 plus random traffic on every configuration.
        for (int c = 0; c < 1200; c++) begin
            for (int i = 0; i < N; i++) begin
                vld_in[i] = 1'($urandom_range(0, 1));
                rdy_in[i] = 1'($urandom_range(0, 1));
                sync[i]   = ($urandom_range(0, 15) == 0);
                din[i]    = {8'($urandom), $urandom, $urandom};
            end
            if (vld_in[3] && rdy_out[3])
                check("T6 push only when not full", (mq[3].size() < dep(3)), 1'b1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
